// File: rtl/mbist_pkg.sv
// Shared types for the MBIST fail logger: FSM encoding, default widths, log entry layout.
package mbist_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/mbist_fail_fifo.sv
// Synchronous FIFO with first-word fall-through head, wrap-bit pointers and same-cycle push/pop.
// A push into a full FIFO succeeds only when a pop completes on the same edge.
module mbist_fail_fifo #(
  parameter int WIDTH     = 80,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_WIDTH:0] r_wr_ptr;
  logic [PTR_WIDTH:0] r_rd_ptr;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]) &&
                      (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]);
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_head_dat = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!i_flush && w_push_ok) begin
      r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_WIDTH+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: captures {address, rdata} per error in RUN, counts faults, tracks IDLE/RUN/DONE.
// MBIST_FAIL_LOG_DEDUP_EN suppresses pushes that repeat the last stored address.
module mbist_fail_logger
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = mbist_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mbist_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_start,
  input  logic                  error,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  marcha_complete,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [DATA_WIDTH-1:0] log_data,
  output logic [ADDR_WIDTH-1:0] fault_count,
  output logic                  log_overflow,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int W = ADDR_WIDTH + DATA_WIDTH;

  state_t                r_state;
  logic                  r_busy, r_done, r_pass;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_overflow;
  logic [ADDR_WIDTH-1:0] w_count_nxt;
  logic                  w_accept, w_push_req, w_push, w_pop;
  logic                  w_full, w_empty;
  logic [W-1:0]          w_head;

  assign w_accept    = (r_state == RUN) && error && !test_start;
  assign w_pop       = !w_empty && log_ready;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_count_nxt = (w_accept && (r_count != '1)) ? r_count + ADDR_WIDTH'(1) : r_count;

`ifdef MBIST_FAIL_LOG_DEDUP_EN
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_last_vld;

  assign w_push_req = w_accept && !(r_last_vld && (address == r_last_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_addr <= '0;
      r_last_vld  <= 1'b0;
    end else if (test_start) begin
      r_last_vld  <= 1'b0;
    end else if (w_push) begin
      r_last_addr <= address;
      r_last_vld  <= 1'b1;
    end
  end
`else
  assign w_push_req = w_accept;
`endif

  mbist_fail_fifo #(
    .WIDTH     (W),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (test_start),
    .i_push     (w_push),
    .i_push_dat ({address, rdata}),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Counter keeps counting drops; overflow only when a push is truly lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (test_start) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (test_start) begin
      r_state <= RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (r_state == RUN && marcha_complete) begin
      r_state <= DONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b1;
      r_pass  <= (w_count_nxt == '0);
    end
  end

  assign log_valid    = !w_empty;
  assign log_addr     = w_head[DATA_WIDTH +: ADDR_WIDTH];
  assign log_data     = w_head[DATA_WIDTH-1:0];
  assign fault_count  = r_count;
  assign log_overflow = r_overflow;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Directed self-checking bench for mbist_fail_logger (default build; dedup expectations follow MBIST_FAIL_LOG_DEDUP_EN).
module tb_mbist_fail_logger;
  import mbist_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  test_start = 1'b0;
  logic                  error = 1'b0;
  logic [ADDR_WIDTH-1:0] address = '0;
  logic [DATA_WIDTH-1:0] rdata = '0;
  logic                  marcha_complete = 1'b0;
  logic                  log_valid;
  logic                  log_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] log_addr;
  logic [DATA_WIDTH-1:0] log_data;
  logic [ADDR_WIDTH-1:0] fault_count;
  logic                  log_overflow;
  logic                  busy;
  logic                  done;
  logic                  pass;

  int n_checks = 0;
  int n_fail   = 0;

  mbist_fail_logger dut (
    .clk             (clk),
    .rst             (rst),
    .test_start      (test_start),
    .error           (error),
    .address         (address),
    .rdata           (rdata),
    .marcha_complete (marcha_complete),
    .log_valid       (log_valid),
    .log_ready       (log_ready),
    .log_addr        (log_addr),
    .log_data        (log_data),
    .fault_count     (fault_count),
    .log_overflow    (log_overflow),
    .busy            (busy),
    .done            (done),
    .pass            (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input logic [15:0] a);
    mk_data = {16'hC0DE, 16'h5A5A, ~a, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    test_start = 1'b1;
    step();
    test_start = 1'b0;
  endtask

  task automatic complete_pulse();
    marcha_complete = 1'b1;
    step();
    marcha_complete = 1'b0;
  endtask

  task automatic err(input logic [15:0] a);
    error   = 1'b1;
    address = a;
    rdata   = mk_data(a);
    step();
    error   = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] a);
    chk({tag, "_vld"},  64'(log_valid), 64'd1);
    chk({tag, "_addr"}, 64'(log_addr), 64'(a));
    chk({tag, "_data"}, log_data, mk_data(a));
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"},   64'(log_valid), 64'd0);
    chk({tag, "_addr"},  64'(log_addr), 64'd0);
    chk({tag, "_data"},  log_data, 64'd0);
    chk({tag, "_cnt"},   64'(fault_count), 64'd0);
    chk({tag, "_ovf"},   64'(log_overflow), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_pass"},  64'(pass), 64'd0);
  endtask

  initial begin
    #2;
    check_reset_outputs("rst0");
    step();
    #2 rst = 1'b0;
    step();

    // Basic capture, ordered readout, DONE flags
    start_pulse();
    chk("t1_busy", 64'(busy), 64'd1);
    err(16'h0010);
    chk("t1_latency_vld", 64'(log_valid), 64'd1);
    err(16'h0020);
    err(16'h0030);
    complete_pulse();
    chk("t1_cnt",  64'(fault_count), 64'd3);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy_lo", 64'(busy), 64'd0);
    chk("t1_pass", 64'(pass), 64'd0);
    pop_expect("t1_e0", 16'h0010);
    pop_expect("t1_e1", 16'h0020);
    pop_expect("t1_e2", 16'h0030);
    chk("t1_empty", 64'(log_valid), 64'd0);
    err(16'h0040);
    chk("t1_done_err_cnt", 64'(fault_count), 64'd3);
    chk("t1_done_err_vld", 64'(log_valid), 64'd0);

    // Clean run
    start_pulse();
    complete_pulse();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_pass", 64'(pass), 64'd1);
    chk("t2_vld",  64'(log_valid), 64'd0);
    chk("t2_cnt",  64'(fault_count), 64'd0);

    // Overflow: 10 errors into 8 entries
    start_pulse();
    chk("t3_pass_cleared", 64'(pass), 64'd0);
    for (int i = 0; i < 10; i++) err(16'h0100 + 16'(i));
    chk("t3_cnt", 64'(fault_count), 64'd10);
    chk("t3_ovf", 64'(log_overflow), 64'd1);
    for (int i = 0; i < 8; i++) pop_expect("t3_pop", 16'h0100 + 16'(i));
    chk("t3_empty", 64'(log_valid), 64'd0);

    // Error coincident with test_start is ignored; full + push + pop keeps full
    error   = 1'b1;
    address = 16'hDEAD;
    rdata   = mk_data(16'hDEAD);
    start_pulse();
    error   = 1'b0;
    chk("t4_ovf_clr", 64'(log_overflow), 64'd0);
    chk("t4_cnt0",    64'(fault_count), 64'd0);
    chk("t4_vld0",    64'(log_valid), 64'd0);
    for (int i = 0; i < 8; i++) err(16'h0200 + 16'(i));
    chk("t4_head", 64'(log_addr), 64'h0200);
    log_ready = 1'b1;
    err(16'h02FF);
    log_ready = 1'b0;
    chk("t4_ovf", 64'(log_overflow), 64'd0);
    chk("t4_cnt", 64'(fault_count), 64'd9);
    for (int i = 1; i < 8; i++) pop_expect("t4_pop", 16'h0200 + 16'(i));
    pop_expect("t4_last", 16'h02FF);
    chk("t4_empty", 64'(log_valid), 64'd0);

    // Repeated address
    start_pulse();
    err(16'h0005);
    err(16'h0005);
    err(16'h0006);
    chk("t5_cnt", 64'(fault_count), 64'd3);
    pop_expect("t5_e0", 16'h0005);
`ifndef MBIST_FAIL_LOG_DEDUP_EN
    pop_expect("t5_dup", 16'h0005);
`endif
    pop_expect("t5_e1", 16'h0006);
    chk("t5_empty", 64'(log_valid), 64'd0);

    // Asynchronous reset mid-run
    start_pulse();
    err(16'h0011);
    err(16'h0022);
    err(16'h0033);
    chk("t6_pre_vld", 64'(log_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    #1 rst = 1'b0;
    step();
    chk("t6_idle_vld", 64'(log_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
